rotate_amount_finder32: RTL

Sequential inverse of the team's 32-bit rotator. Given an original word and a rotated word, it searches iteratively, one candidate rotation per clock, for the rotation that maps one to the other. It reports the amount and direction in the same move/direction encoding the rotator consumes: 1 = RIGHT, 0 = LEFT, move 0-31. It sits beside the rotator in the lab datapath as a decoder/checker and uses a start/done handshake.

---
 rtl/rot_pkg.sv | 18 +
 rtl/rotate_amount_finder32.sv | 100 ++++++++++
 2 files changed

// File: rtl/rot_pkg.sv
// Shared definitions for the 32-bit rotator and its inverse search block.
//   rot_state_t : search FSM states (IDLE, SEARCH, DONE)
//   DIR_RIGHT / DIR_LEFT : direction encoding consumed by the rotator
//   ROT_WIDTH   : default data word width
package rot_pkg;

    localparam int unsigned ROT_WIDTH = 32;

    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_LEFT  = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } rot_state_t;

endpackage : rot_pkg

// File: rtl/rotate_amount_finder32.sv
// Iterative inverse of the rotator: given an original word and a rotated
// word, tries one left rotation per clock and reports the smallest matching
// amount in the rotator's move/direction encoding.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : request a search (sampled only when idle)
//   sample, rotated     : original and target words, captured on the start edge
//   busy                : high while searching or presenting the result
//   done                : one-cycle pulse when found/move/direction are valid
//   found               : a matching rotation exists
//   move, direction     : rotation amount and direction (1 = RIGHT, 0 = LEFT)
module rotate_amount_finder32
    import rot_pkg::*;
#(
    parameter  int unsigned WIDTH  = ROT_WIDTH,
    localparam int unsigned MOVE_W = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  sample,
    input  logic [WIDTH-1:0]  rotated,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [MOVE_W-1:0] move,
    output logic              direction
);

    localparam logic [MOVE_W-1:0] HALF = MOVE_W'(WIDTH / 2);
    localparam logic [MOVE_W-1:0] LAST = MOVE_W'(WIDTH - 1);

    rot_state_t        state;
    logic [WIDTH-1:0]  cur;
    logic [WIDTH-1:0]  tgt;
    logic [MOVE_W-1:0] cnt;

    // Search FSM with datapath and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur       <= '0;
            tgt       <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            found     <= 1'b0;
            move      <= '0;
            direction <= DIR_LEFT;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur   <= sample;
                        tgt   <= rotated;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SEARCH;
                    end
                end
                SEARCH: begin
                    // Compare before giving up so a match at cnt=WIDTH-1 is still found.
                    if (cur == tgt) begin
                        state <= DONE;
                        done  <= 1'b1;
                        found <= 1'b1;
                        // Amounts past half a word are cheaper as a right rotate;
                        // exactly half stays LEFT.
                        if (cnt <= HALF) begin
                            move      <= cnt;
                            direction <= DIR_LEFT;
                        end else begin
                            move      <= MOVE_W'(WIDTH - 32'(cnt));
                            direction <= DIR_RIGHT;
                        end
                    end else if (cnt == LAST) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        found     <= 1'b0;
                        move      <= '0;
                        direction <= DIR_LEFT;
                    end else begin
                        cur <= {cur[WIDTH-2:0], cur[WIDTH-1]};
                        cnt <= cnt + MOVE_W'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : rotate_amount_finder32
